dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port synchronous data RAM between the ARM core data port
//  (CPU) and one external requester (EXT, e.g. a loader or display reader).
//  Sits between arm/LargerRAM. Sequences each access, absorbs the RAM read
//  latency and stalls the CPU until its access completes.
// PARAMETERS
//  ADDR_W     32  address width, all ports
//  DATA_W     32  data width, all ports
//  RD_LAT     1   RAM read latency in cycles (mem_q valid RD_LAT cycles after issue), >=1
//  STARVE_MAX 4   consecutive EXT wait cycles before EXT takes priority, >=1
// PORTS
//  clk        in  1       clock, all logic on rising edge
//  reset      in  1       asynchronous, active-low reset
//  cpu_req    in  1       CPU access request, held with we/addr/wdata until cpu_ack
//  cpu_we     in  1       1=write, 0=read
//  cpu_addr   in  ADDR_W  CPU address
//  cpu_wdata  in  DATA_W  CPU write data
//  cpu_rdata  out DATA_W  read data, valid with cpu_ack, held until next CPU read ack
//  cpu_ack    out 1       one-cycle completion pulse
//  cpu_stall  out 1       cpu_req & ~cpu_ack; freezes PC/regfile writes
//  ext_req/ext_we/ext_addr/ext_wdata/ext_rdata/ext_ack  same as cpu_* for EXT
//  mem_wren   out 1       RAM write enable
//  mem_addr   out ADDR_W  RAM address
//  mem_data   out DATA_W  RAM write data
//  mem_q      in  DATA_W  RAM read data
// BEHAVIOUR
//  - Reset (async, reset=0): state IDLE, owner NONE, starve_cnt=0, rdata regs=0,
//    mem_wren=0, acks=0, mem_addr/mem_data=0. mem_wren drops immediately on assert.
//  - FSM: IDLE -> ISSUE -> (write: IDLE | read: WAIT) ; WAIT -> IDLE after RD_LAT cycles.
//  - IDLE: no output activity. If any req: latch owner; next state ISSUE.
//    Both req: CPU wins unless starve_cnt==STARVE_MAX, then EXT wins.
//  - ISSUE: mem_addr/mem_data/mem_wren driven from owner's inputs (wren=owner we).
//    Write: owner ack pulses in this cycle; RAM commits at closing edge; -> IDLE.
//    Read: -> WAIT, lat_cnt=RD_LAT-1.
//  - WAIT: mem_addr held; when lat_cnt==0 owner ack pulses, owner rdata = mem_q
//    combinationally and registered at same edge; -> IDLE; else lat_cnt--.
//  - Latency req->ack: write 2 cycles, read 2+RD_LAT cycles (incl. IDLE cycle).
//    Back-to-back same requester: one IDLE cycle between accesses.
//  - starve_cnt: +1 each cycle ext_req=1 and EXT not owner, saturates at STARVE_MAX;
//    cleared to 0 on cycle EXT enters ISSUE.
//  - Non-owner ack never asserted; non-owner rdata unchanged.
//  - Requester dropping req mid-access: access still completes, ack still pulses.
//  - Address/data changes mid-access: ignored only for mem_data in WAIT; protocol
//    violation otherwise (bench asserts stability).
// CONFIGURATION
//  ARB_PERF_EN defined: adds outputs perf_stall_cnt[31:0] (cycles cpu_stall=1) and
//    perf_ext_cnt[31:0] (EXT grants); saturating at 2^32-1, cleared by reset.
//  Not defined: ports still present, tied to 0; no counter logic.
// STRUCTURE
//  Package dmem_arb_pkg: state_t {IDLE,ISSUE,WAIT}, owner_t {NONE,CPU,EXT},
//    PERF_W=32.
//  Sub-module dmem_arb_perf (counters, instantiated only under ARB_PERF_EN).
// TESTING
//  1 CPU write addr=0x10 data=0xDEADBEEF, no EXT -> mem_wren=1 one cycle, cpu_ack 2nd cycle.
//  2 CPU read 0x10 after (1), RD_LAT=1 -> cpu_ack at cycle 3, cpu_rdata=0xDEADBEEF,
//    cpu_stall=1 cycles 1-2.
//  3 cpu_req and ext_req held continuously, STARVE_MAX=4 -> EXT granted after 4 wait
//    cycles, then CPU; no ack overlap, ext_ack data correct.
//  4 EXT read 0x20 while CPU idle, RD_LAT=3 -> ext_ack at cycle 5, cpu_ack never 1.
//  5 reset=0 asserted in WAIT -> mem_wren/acks 0 immediately, state IDLE; after release
//    pending CPU read reissued and completes.
//  6 ARB_PERF_EN: test 3 run 20 cycles -> perf_ext_cnt and perf_stall_cnt match model;
//    without macro both read 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-RAM arbiter.
// The optional ARB_PERF_EN build uses sat_inc for its saturating counters.
package dmem_arb_pkg;

  localparam int PERF_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {NONE, CPU, EXT} owner_t;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_arb_perf.sv
// Saturating performance counters for dmem_arbiter.
// Compiled only when ARB_PERF_EN is defined.
`ifdef ARB_PERF_EN
module dmem_arb_perf
  import dmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              ext_grant,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] ext_cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      ext_cnt   <= '0;
    end else begin
      if (stall)     stall_cnt <= sat_inc(stall_cnt);
      if (ext_grant) ext_cnt   <= sat_inc(ext_cnt);
    end
  end

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU data port and one EXT requester.
// Optional ARB_PERF_EN adds stall / EXT-grant counters; otherwise perf ports read 0.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_ext_cnt
);

  localparam int LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  state_t              state, state_nx;
  owner_t              owner, owner_nx;
  logic                acc_we;
  logic [LAT_W-1:0]    lat_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic [DATA_W-1:0]   cpu_rdata_r, ext_rdata_r;
  logic                grant_cpu, grant_ext, ack, rd_done;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  assign sel_addr  = (owner == EXT) ? ext_addr  : cpu_addr;
  assign sel_wdata = (owner == EXT) ? ext_wdata : cpu_wdata;

  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    grant_cpu = 1'b0;
    grant_ext = 1'b0;
    ack       = 1'b0;
    rd_done   = 1'b0;
    mem_wren  = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    case (state)
      IDLE: begin
        // CPU has priority until EXT has waited STARVE_MAX cycles
        if (cpu_req && !(ext_req && starve_cnt == STARVE_W'(STARVE_MAX))) begin
          grant_cpu = 1'b1;
          owner_nx  = CPU;
          state_nx  = ISSUE;
        end else if (ext_req) begin
          grant_ext = 1'b1;
          owner_nx  = EXT;
          state_nx  = ISSUE;
        end
      end
      ISSUE: begin
        mem_addr = sel_addr;
        mem_data = sel_wdata;
        mem_wren = acc_we;
        if (acc_we) begin
          ack      = 1'b1;
          state_nx = IDLE;
          owner_nx = NONE;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        mem_addr = sel_addr;
        if (lat_cnt == '0) begin
          ack      = 1'b1;
          rd_done  = 1'b1;
          state_nx = IDLE;
          owner_nx = NONE;
        end
      end
      default: begin
        state_nx = IDLE;
        owner_nx = NONE;
      end
    endcase
  end

  assign cpu_ack   = ack && (owner == CPU);
  assign ext_ack   = ack && (owner == EXT);
  assign cpu_stall = cpu_req && !cpu_ack;
  // read data appears in the ack cycle and is held afterwards
  assign cpu_rdata = (rd_done && owner == CPU) ? mem_q : cpu_rdata_r;
  assign ext_rdata = (rd_done && owner == EXT) ? mem_q : ext_rdata_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= NONE;
      acc_we      <= 1'b0;
      lat_cnt     <= '0;
      starve_cnt  <= '0;
      cpu_rdata_r <= '0;
      ext_rdata_r <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      // direction is latched at grant so a dropped request cannot corrupt it
      if (grant_cpu)      acc_we <= cpu_we;
      else if (grant_ext) acc_we <= ext_we;
      if (state == ISSUE)                     lat_cnt <= LAT_W'(RD_LAT - 1);
      else if (state == WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
      if (grant_ext)
        starve_cnt <= '0;
      else if (ext_req && owner != EXT && starve_cnt != STARVE_W'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
      if (rd_done && owner == CPU) cpu_rdata_r <= mem_q;
      if (rd_done && owner == EXT) ext_rdata_r <= mem_q;
    end
  end

`ifdef ARB_PERF_EN
  dmem_arb_perf u_perf (
    .clk       (clk),
    .reset     (reset),
    .stall     (cpu_stall),
    .ext_grant (grant_ext),
    .stall_cnt (perf_stall_cnt),
    .ext_cnt   (perf_ext_cnt)
  );
`else
  assign perf_stall_cnt = '0;
  assign perf_ext_cnt   = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one RD_LAT=1 instance with a RAM model,
// one RD_LAT=3 instance with an address-derived read pipeline.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ext_req, ext_we, ext_ack;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        mem_wren;
  logic [31:0] mem_addr, mem_data, mem_q;
  logic [31:0] perf_stall_cnt, perf_ext_cnt;

  logic        b_cpu_req, b_cpu_we, b_cpu_ack, b_cpu_stall;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
  logic        b_ext_req, b_ext_we, b_ext_ack;
  logic [31:0] b_ext_addr, b_ext_wdata, b_ext_rdata;
  logic        b_mem_wren;
  logic [31:0] b_mem_addr, b_mem_data, b_mem_q;
  logic [31:0] b_perf_stall_cnt, b_perf_ext_cnt;

  int n_chk = 0;
  int n_err = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_data(mem_data), .mem_q(mem_q),
    .perf_stall_cnt(perf_stall_cnt), .perf_ext_cnt(perf_ext_cnt)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack), .cpu_stall(b_cpu_stall),
    .ext_req(b_ext_req), .ext_we(b_ext_we), .ext_addr(b_ext_addr), .ext_wdata(b_ext_wdata),
    .ext_rdata(b_ext_rdata), .ext_ack(b_ext_ack),
    .mem_wren(b_mem_wren), .mem_addr(b_mem_addr), .mem_data(b_mem_data), .mem_q(b_mem_q),
    .perf_stall_cnt(b_perf_stall_cnt), .perf_ext_cnt(b_perf_ext_cnt)
  );

  // single-port RAM, one-cycle read latency
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr[7:0]] <= mem_data;
    mem_q <= ram[mem_addr[7:0]];
  end

  // three-cycle read pipeline returning {16'hC0DE, addr[15:0]}
  logic [31:0] q3 [3];
  always @(posedge clk) begin
    q3[0] <= {16'hC0DE, b_mem_addr[15:0]};
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign b_mem_q = q3[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [13:0] t3_cpu_ack;
  logic [13:0] t3_ext_ack;

  initial begin
    reset = 1'b1;
    {cpu_req, cpu_we, ext_req, ext_we} = '0;
    {cpu_addr, cpu_wdata, ext_addr, ext_wdata} = '0;
    {b_cpu_req, b_cpu_we, b_ext_req, b_ext_we} = '0;
    {b_cpu_addr, b_cpu_wdata, b_ext_addr, b_ext_wdata} = '0;
    #1 reset = 1'b0;
    #2;
    // reset state
    check("rst_wren", mem_wren, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_ext_ack", ext_ack, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_ext_rdata", ext_rdata, 0);
    check("rst_stall", cpu_stall, 0);
    check("rst_perf_stall", perf_stall_cnt, 0);
    check("rst_perf_ext", perf_ext_cnt, 0);
    tick();
    tick();
    reset = 1'b1;

    // EXT read 0x20 on the RD_LAT=3 instance: ack in the 5th cycle
    b_ext_req = 1'b1; b_ext_we = 1'b0; b_ext_addr = 32'h20;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("t4_ext_ack", b_ext_ack, (i == 4));
      check("t4_cpu_ack", b_cpu_ack, 0);
      if (i == 4) begin
        check("t4_ext_rdata", b_ext_rdata, 32'hC0DE0020);
        b_ext_req = 1'b0;
      end
      tick();
    end
    check("t4_rdata_hold", b_ext_rdata, 32'hC0DE0020);

    // CPU write 0x10 = DEADBEEF
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    #1;
    check("t1_c1_ack", cpu_ack, 0);
    check("t1_c1_stall", cpu_stall, 1);
    check("t1_c1_wren", mem_wren, 0);
    tick();
    check("t1_c2_wren", mem_wren, 1);
    check("t1_c2_addr", mem_addr, 32'h10);
    check("t1_c2_data", mem_data, 32'hDEADBEEF);
    check("t1_c2_ack", cpu_ack, 1);
    check("t1_c2_stall", cpu_stall, 0);
    cpu_req = 1'b0;
    tick();
    check("t1_c3_wren", mem_wren, 0);
    check("t1_c3_ack", cpu_ack, 0);

    // CPU read 0x10: ack in the 3rd cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    #1;
    check("t2_c1_ack", cpu_ack, 0);
    check("t2_c1_stall", cpu_stall, 1);
    tick();
    check("t2_c2_ack", cpu_ack, 0);
    check("t2_c2_stall", cpu_stall, 1);
    check("t2_c2_wren", mem_wren, 0);
    check("t2_c2_addr", mem_addr, 32'h10);
    tick();
    check("t2_c3_ack", cpu_ack, 1);
    check("t2_c3_rdata", cpu_rdata, 32'hDEADBEEF);
    cpu_req = 1'b0;
    tick();
    check("t2_c4_ack", cpu_ack, 0);
    check("t2_rdata_hold", cpu_rdata, 32'hDEADBEEF);
    check("t2_ext_rdata", ext_rdata, 0);

    // both requesters held: CPU, CPU, EXT after 4 waits, repeating every 7 cycles
    t3_cpu_ack = 14'h050A;
    t3_ext_ack = 14'h2040;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h11111111;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
    #1;
    for (int i = 0; i < 14; i++) begin
      check("t3_cpu_ack", cpu_ack, t3_cpu_ack[i]);
      check("t3_ext_ack", ext_ack, t3_ext_ack[i]);
      if (t3_ext_ack[i]) check("t3_ext_rdata", ext_rdata, 32'hDEADBEEF);
      if (i == 13) begin
        cpu_req = 1'b0;
        ext_req = 1'b0;
      end
      tick();
    end
    check("t3_cpu_rdata_hold", cpu_rdata, 32'hDEADBEEF);

    // CPU drops req during ISSUE: access still completes
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
    #1;
    tick();
    check("drop_addr", mem_addr, 32'h30);
    cpu_req = 1'b0;
    tick();
    check("drop_ack", cpu_ack, 1);
    check("drop_rdata", cpu_rdata, 32'h11111111);
    check("drop_stall", cpu_stall, 0);
    tick();
    check("drop_idle_ack", cpu_ack, 0);

    // reset asserted in WAIT, then the held read is reissued
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    #1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("t5_wren", mem_wren, 0);
    check("t5_ack", cpu_ack, 0);
    check("t5_addr", mem_addr, 0);
    check("t5_cpu_rdata", cpu_rdata, 0);
    check("t5_ext_rdata", ext_rdata, 0);
    check("t5_stall", cpu_stall, 1);
    tick();
    reset = 1'b1;
    #1;
    check("t5_r1_ack", cpu_ack, 0);
    tick();
    check("t5_r2_addr", mem_addr, 32'h10);
    check("t5_r2_ack", cpu_ack, 0);
    tick();
    check("t5_r3_ack", cpu_ack, 1);
    check("t5_r3_rdata", cpu_rdata, 32'hDEADBEEF);
    cpu_req = 1'b0;
    tick();

    // perf: contention pattern for 20 cycles from a fresh reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h11111111;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
    #1;
    repeat (20) tick();
`ifdef ARB_PERF_EN
    check("t6_perf_stall", perf_stall_cnt, 14);
    check("t6_perf_ext", perf_ext_cnt, 3);
`else
    check("t6_perf_stall", perf_stall_cnt, 0);
    check("t6_perf_ext", perf_ext_cnt, 0);
`endif
    cpu_req = 1'b0;
    ext_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
